// File: rtl/ps2_pkg.sv
// Shared scan-code constants, event field layout and decoder state type
// for the PS/2 keyboard decoder.
package ps2_pkg;

    localparam logic [7:0] KC_E0     = 8'hE0;
    localparam logic [7:0] KC_E1     = 8'hE1;
    localparam logic [7:0] KC_F0     = 8'hF0;
    localparam logic [7:0] KC_FA     = 8'hFA;
    localparam logic [7:0] KC_FE     = 8'hFE;
    localparam logic [7:0] KC_AA     = 8'hAA;
    localparam logic [7:0] KC_FC     = 8'hFC;
    localparam logic [7:0] KC_FD     = 8'hFD;
    localparam logic [7:0] KC_00     = 8'h00;
    localparam logic [7:0] KC_FF     = 8'hFF;
    localparam logic [7:0] KC_LSHIFT = 8'h12;
    localparam logic [7:0] KC_RSHIFT = 8'h59;

    // Event word layout: {ext, brk, code[7:0]}
    localparam int EVT_W        = 10;
    localparam int EVT_EXT      = 9;
    localparam int EVT_BRK      = 8;
    localparam int EVT_CODE_MSB = 7;

    // Pause (E1 ...) is followed by seven more bytes
    localparam logic [2:0] E1_SKIP_LEN = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_E0     = 2'd1,
        S_F0     = 2'd2,
        S_E1SKIP = 2'd3
    } ps2_state_e;

    function automatic logic [EVT_W-1:0] make_evt(input logic ext, input logic brk,
                                                  input logic [7:0] code);
        logic [EVT_W-1:0] e;
        e                 = '0;
        e[EVT_EXT]        = ext;
        e[EVT_BRK]        = brk;
        e[EVT_CODE_MSB:0] = code;
        return e;
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] code);
        return (code == KC_LSHIFT) || (code == KC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO with occupancy count and sticky overflow flag.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk6x,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [4:0]       count_o,
    output logic             ovf_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [4:0]       r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_set;

    assign w_full    = (r_count == 5'(DEPTH));
    assign w_empty   = (r_count == 5'd0);
    assign w_pop     = pop_i && !w_empty;
    assign w_push    = push_i && (!w_full || w_pop);
    assign w_ovf_set = push_i && w_full && !w_pop;

    always_ff @(posedge clk6x) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 5'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (ovf_clr_i) r_ovf <= 1'b0;
        end
    end

    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign valid_o = !w_empty;
    assign count_o = r_count;
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into {ext, brk, code}
// events, raises status pulses, and abandons stalled prefixes after a timeout.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH        = 8,
    parameter int PREFIX_TIMEOUT_US = 2000
) (
    input  logic             clk6x,
    input  logic             resetn,
    input  logic             ck1us,
    input  logic [7:0]       code_rx_i,
    input  logic             code_rx_v_i,
    output logic [EVT_W-1:0] evt_o,
    output logic             evt_valid_o,
    input  logic             evt_rd_i,
    output logic [4:0]       evt_count_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    output logic             ack_o,
    output logic             resend_o,
    output logic             bat_ok_o,
    output logic             kbd_err_o,
    output logic             proto_err_o,
    output logic [1:0]       dbg_state_o
);

    localparam int TW = $clog2(PREFIX_TIMEOUT_US + 1);

    ps2_state_e       r_state;
    ps2_state_e       w_state_nxt;
    logic             r_ext;
    logic             w_ext_nxt;
    logic [2:0]       r_skip;
    logic [2:0]       w_skip_nxt;
    logic [TW-1:0]    r_timer;
    logic             w_timeout;
    logic             w_push;
    logic [EVT_W-1:0] w_push_data;
    logic             w_ack, w_resend, w_bat, w_kerr, w_perr;
    logic             r_ack, r_resend, r_bat, r_kerr, r_perr;

    // A byte arriving in the expiry cycle takes priority over the timeout
    assign w_timeout = (r_state != S_IDLE) && (r_timer == '0) && !code_rx_v_i;

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ext   <= 1'b0;
            r_skip  <= 3'd0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ext   <= w_ext_nxt;
            r_skip  <= w_skip_nxt;
            if (w_state_nxt == S_IDLE)  r_timer <= '0;
            else if (code_rx_v_i)       r_timer <= TW'(PREFIX_TIMEOUT_US);
            else if (ck1us && r_timer != '0) r_timer <= r_timer - TW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ext_nxt   = r_ext;
        w_skip_nxt  = r_skip;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (code_rx_v_i) begin
            case (r_state)
                S_IDLE: begin
                    case (code_rx_i)
                        KC_E0:   begin w_state_nxt = S_E0; w_ext_nxt = 1'b1; end
                        KC_F0:   begin w_state_nxt = S_F0; w_ext_nxt = 1'b0; end
                        KC_E1:   begin w_state_nxt = S_E1SKIP; w_skip_nxt = E1_SKIP_LEN; end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
                S_E0: begin
                    if (code_rx_i == KC_F0)      w_state_nxt = S_F0;
                    else if (code_rx_i != KC_E0) w_state_nxt = S_IDLE;
                end
                S_F0: w_state_nxt = S_IDLE;
                S_E1SKIP: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip <= 3'd1) begin
                        w_skip_nxt  = 3'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_state_nxt == S_IDLE) w_ext_nxt = 1'b0;
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_ack       = 1'b0;
        w_resend    = 1'b0;
        w_bat       = 1'b0;
        w_kerr      = 1'b0;
        w_perr      = w_timeout;
        if (code_rx_v_i) begin
            case (r_state)
                S_IDLE: begin
                    case (code_rx_i)
                        KC_E0, KC_F0, KC_E1:        begin end
                        KC_FA:                      w_ack    = 1'b1;
                        KC_FE:                      w_resend = 1'b1;
                        KC_AA:                      w_bat    = 1'b1;
                        KC_FC, KC_FD, KC_00, KC_FF: w_kerr   = 1'b1;
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = make_evt(1'b0, 1'b0, code_rx_i);
                        end
                    endcase
                end
                S_E0: begin
                    if (code_rx_i != KC_F0 && code_rx_i != KC_E0 && !is_fake_shift(code_rx_i)) begin
                        w_push      = 1'b1;
                        w_push_data = make_evt(1'b1, 1'b0, code_rx_i);
                    end
                end
                S_F0: begin
                    if (code_rx_i == KC_E0 || code_rx_i == KC_F0 || code_rx_i == KC_E1) begin
                        w_perr = 1'b1;
                    end else if (!(r_ext && is_fake_shift(code_rx_i))) begin
                        w_push      = 1'b1;
                        w_push_data = make_evt(r_ext, 1'b1, code_rx_i);
                    end
                end
                S_E1SKIP: begin
                    if (r_skip <= 3'd1) begin
                        w_push      = 1'b1;
                        w_push_data = make_evt(1'b1, 1'b0, KC_E1);
                    end
                end
                default: begin end
            endcase
        end
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            r_ack    <= 1'b0;
            r_resend <= 1'b0;
            r_bat    <= 1'b0;
            r_kerr   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_ack    <= w_ack;
            r_resend <= w_resend;
            r_bat    <= w_bat;
            r_kerr   <= w_kerr;
            r_perr   <= w_perr;
        end
    end

    assign ack_o       = r_ack;
    assign resend_o    = r_resend;
    assign bat_ok_o    = r_bat;
    assign kbd_err_o   = r_kerr;
    assign proto_err_o = r_perr;
    assign dbg_state_o = r_state;

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk6x       (clk6x),
        .resetn      (resetn),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (evt_rd_i),
        .ovf_clr_i   (ovf_clr_i),
        .data_o      (evt_o),
        .valid_o     (evt_valid_o),
        .count_o     (evt_count_o),
        .ovf_o       (ovf_o)
    );

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: directed scenarios plus a random byte stream,
// checked against a sequence-level decode model and an expected event queue.
module tb_ps2_kbd_decoder;

    localparam int DEPTH = 8;

    logic        clk6x;
    logic        resetn;
    logic        ck1us;
    logic [7:0]  code_rx_i;
    logic        code_rx_v_i;
    logic [9:0]  evt_o;
    logic        evt_valid_o;
    logic        evt_rd_i;
    logic [4:0]  evt_count_o;
    logic        ovf_o;
    logic        ovf_clr_i;
    logic        ack_o, resend_o, bat_ok_o, kbd_err_o, proto_err_o;
    logic [1:0]  dbg_state_o;
    logic [4:0]  obs_pulse;

    int          errors;
    int          checks;
    int          tick_cnt;

    logic [9:0]  exp_q[$];
    logic [7:0]  seq[$];
    logic        exp_ovf;
    logic [4:0]  exp_pulse;

    assign obs_pulse = {ack_o, resend_o, bat_ok_o, kbd_err_o, proto_err_o};

    ps2_kbd_decoder #(
        .FIFO_DEPTH        (DEPTH),
        .PREFIX_TIMEOUT_US (2000)
    ) dut (
        .clk6x       (clk6x),
        .resetn      (resetn),
        .ck1us       (ck1us),
        .code_rx_i   (code_rx_i),
        .code_rx_v_i (code_rx_v_i),
        .evt_o       (evt_o),
        .evt_valid_o (evt_valid_o),
        .evt_rd_i    (evt_rd_i),
        .evt_count_o (evt_count_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i),
        .ack_o       (ack_o),
        .resend_o    (resend_o),
        .bat_ok_o    (bat_ok_o),
        .kbd_err_o   (kbd_err_o),
        .proto_err_o (proto_err_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and accelerated microsecond tick (one pulse every 4 cycles)
    initial begin
        clk6x = 1'b0;
        forever #5 clk6x = ~clk6x;
    end

    initial begin
        int phase;
        phase    = 0;
        ck1us    = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk6x);
            if (phase == 3) begin
                ck1us = 1'b1;
                tick_cnt++;
                phase = 0;
            end else begin
                ck1us = 1'b0;
                phase++;
            end
        end
    end

    function automatic bit fake(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    // Decode model: interprets the bytes of the pending sequence as a whole
    task automatic model_byte(input logic [7:0] b, output logic [4:0] p,
                              output bit push, output logic [9:0] ev);
        bit ext;
        p = 5'b0; push = 1'b0; ev = '0;
        if (seq.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) seq.push_back(b);
            else if (b == 8'hFA) p = 5'b10000;
            else if (b == 8'hFE) p = 5'b01000;
            else if (b == 8'hAA) p = 5'b00100;
            else if (b == 8'hFC || b == 8'hFD || b == 8'h00 || b == 8'hFF) p = 5'b00010;
            else begin push = 1'b1; ev = {2'b00, b}; end
        end else if (seq[0] == 8'hE1) begin
            seq.push_back(b);
            if (seq.size() == 8) begin push = 1'b1; ev = 10'h2E1; seq.delete(); end
        end else if (seq[seq.size()-1] == 8'hF0) begin
            ext = (seq[0] == 8'hE0);
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) p = 5'b00001;
            else if (!(ext && fake(b))) begin push = 1'b1; ev = {ext, 1'b1, b}; end
            seq.delete();
        end else begin
            if (b == 8'hE0 || b == 8'hF0) seq.push_back(b);
            else begin
                if (!fake(b)) begin push = 1'b1; ev = {2'b10, b}; end
                seq.delete();
            end
        end
    endtask

    task automatic apply_reset();
        code_rx_v_i = 1'b0; evt_rd_i = 1'b0; ovf_clr_i = 1'b0; code_rx_i = 8'h00;
        resetn = 1'b0;
        repeat (3) @(posedge clk6x);
        #1;
        resetn = 1'b1;
        seq.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    // Drives one cycle of stimulus, updates the model, returns at the sample point of the next cycle
    task automatic drive_cycle(input bit strobe, input logic [7:0] b, input bit pop, input bit clr);
        bit         push;
        logic [9:0] ev;
        push = 1'b0; ev = '0; exp_pulse = 5'b0;
        if (strobe) model_byte(b, exp_pulse, push, ev);
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (push && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else begin
            if (push) exp_q.push_back(ev);
            if (clr) exp_ovf = 1'b0;
        end
        code_rx_i = b; code_rx_v_i = strobe; evt_rd_i = pop; ovf_clr_i = clr;
        @(posedge clk6x);
        #1;
        code_rx_v_i = 1'b0; evt_rd_i = 1'b0; ovf_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk6x);
        #1;
        checks++;
        if ({evt_valid_o, evt_count_o, ovf_o, evt_o, obs_pulse, dbg_state_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d ovf=%b evt=%h pulses=%b state=%0d, all must be 0",
                     evt_valid_o, evt_count_o, ovf_o, evt_o, obs_pulse, dbg_state_o);
        end
        apply_reset();
    endtask

    task automatic test_make();
        apply_reset();
        drive_cycle(1, 8'h1C, 0, 0);
        checks++;
        if ({evt_valid_o, evt_count_o, evt_o} !== {1'b1, 5'd1, 10'h01C}) begin
            errors++;
            $display("FAIL make_1c: valid=%b count=%0d evt=%h, need 1/1/01c", evt_valid_o, evt_count_o, evt_o);
        end
        drive_cycle(0, 8'h00, 1, 0);
        checks++;
        if ({evt_valid_o, evt_count_o} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL make_pop: valid=%b count=%0d, need 0/0", evt_valid_o, evt_count_o);
        end
    endtask

    task automatic test_ext_break();
        apply_reset();
        drive_cycle(1, 8'hE0, 0, 0);
        drive_cycle(1, 8'hF0, 0, 0);
        checks++;
        if (evt_count_o !== 5'd0) begin
            errors++;
            $display("FAIL ext_brk_prefix: count=%0d, need 0", evt_count_o);
        end
        drive_cycle(1, 8'h75, 0, 0);
        checks++;
        if ({evt_count_o, evt_o} !== {5'd1, 10'h375}) begin
            errors++;
            $display("FAIL ext_brk_75: count=%0d evt=%h, need 1/375", evt_count_o, evt_o);
        end
        drive_cycle(1, 8'hE0, 0, 0);
        drive_cycle(1, 8'h12, 0, 0);
        checks++;
        if ({evt_count_o, evt_o, dbg_state_o} !== {5'd1, 10'h375, 2'd0}) begin
            errors++;
            $display("FAIL fake_shift: count=%0d evt=%h state=%0d, need 1/375/0", evt_count_o, evt_o, dbg_state_o);
        end
    endtask

    task automatic test_pause();
        logic [7:0] bytes [8];
        bytes = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1, bytes[i], 0, 0);
            if (i == 6) begin
                checks++;
                if (evt_count_o !== 5'd0 || obs_pulse !== 5'b0) begin
                    errors++;
                    $display("FAIL pause_mid: count=%0d pulses=%b, need 0/00000", evt_count_o, obs_pulse);
                end
            end
        end
        checks++;
        if ({evt_count_o, evt_o, dbg_state_o} !== {5'd1, 10'h2E1, 2'd0}) begin
            errors++;
            $display("FAIL pause_evt: count=%0d evt=%h state=%0d, need 1/2e1/0", evt_count_o, evt_o, dbg_state_o);
        end
    endtask

    task automatic test_status();
        logic [7:0] bytes [3];
        logic [4:0] want  [3];
        bytes = '{8'hFA, 8'hAA, 8'hFC};
        want  = '{5'b10000, 5'b00100, 5'b00010};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, bytes[i], 0, 0);
            checks++;
            if ({obs_pulse, evt_count_o} !== {want[i], 5'd0}) begin
                errors++;
                $display("FAIL status_%h: pulses=%b count=%0d, need %b/0", bytes[i], obs_pulse, evt_count_o, want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 9; i++) drive_cycle(1, 8'h10 + 8'(i), 0, 0);
        checks++;
        if ({evt_count_o, ovf_o, evt_o} !== {5'd8, 1'b1, 10'h010}) begin
            errors++;
            $display("FAIL ovf_fill: count=%0d ovf=%b head=%h, need 8/1/010", evt_count_o, ovf_o, evt_o);
        end
        drive_cycle(1, 8'h21, 1, 0);
        checks++;
        if ({evt_count_o, evt_o} !== {5'd8, 10'h011}) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d head=%h, need 8/011", evt_count_o, evt_o);
        end
        drive_cycle(1, 8'h22, 0, 1);
        checks++;
        if ({evt_count_o, ovf_o} !== {5'd8, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set_wins: count=%0d ovf=%b, need 8/1", evt_count_o, ovf_o);
        end
        drive_cycle(0, 8'h00, 0, 1);
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, need 0", ovf_o);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++;
            if (evt_o !== (exp_q.size() > 0 ? exp_q[0] : 10'h000) || evt_count_o !== 5'(exp_q.size())) begin
                errors++;
                $display("FAIL drain_%0d: head=%h count=%0d, need %h/%0d", i, evt_o, evt_count_o,
                         exp_q.size() > 0 ? exp_q[0] : 10'h000, exp_q.size());
            end
            drive_cycle(0, 8'h00, 1, 0);
        end
        checks++;
        if ({evt_valid_o, evt_count_o, evt_o} !== '0) begin
            errors++;
            $display("FAIL pop_empty: valid=%b count=%0d evt=%h, need 0/0/000", evt_valid_o, evt_count_o, evt_o);
        end
    endtask

    task automatic test_timeout();
        int  snap;
        bit  seen;
        apply_reset();
        drive_cycle(1, 8'hE0, 0, 0);
        snap = tick_cnt;
        seen = 1'b0;
        for (int i = 0; i < 9000 && !seen; i++) begin
            @(posedge clk6x);
            #1;
            if (proto_err_o) seen = 1'b1;
        end
        checks++;
        if (!seen || (tick_cnt - snap) != 2000) begin
            errors++;
            $display("FAIL timeout_pulse: seen=%b after %0d us, need 1 after 2000 us", seen, tick_cnt - snap);
        end
        seq.delete();
        drive_cycle(1, 8'h1C, 0, 0);
        checks++;
        if ({evt_count_o, evt_o} !== {5'd1, 10'h01C}) begin
            errors++;
            $display("FAIL timeout_next: count=%0d evt=%h, need 1/01c", evt_count_o, evt_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_cycle(1, 8'hE0, 0, 0);
        drive_cycle(1, 8'hF0, 0, 0);
        apply_reset();
        drive_cycle(1, 8'h1C, 0, 0);
        checks++;
        if ({evt_count_o, evt_o, obs_pulse} !== {5'd1, 10'h01C, 5'b0}) begin
            errors++;
            $display("FAIL reset_mid: count=%0d evt=%h pulses=%b, need 1/01c/00000", evt_count_o, evt_o, obs_pulse);
        end
    endtask

    task automatic test_random();
        logic [7:0] status_set [7];
        logic [7:0] b;
        int         r;
        status_set = '{8'hFA, 8'hFE, 8'hAA, 8'hFC, 8'hFD, 8'h00, 8'hFF};
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h2B;
                5:       b = status_set[$urandom_range(0, 6)];
                6:       b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
                default: b = 8'($urandom_range(0, 255));
            endcase
            drive_cycle($urandom_range(0, 4) != 0, b, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            checks++;
            if (obs_pulse !== exp_pulse) begin
                errors++;
                $display("FAIL rnd_pulse_%0d: pulses=%b, need %b", n, obs_pulse, exp_pulse);
            end
            checks++;
            if ({evt_valid_o, evt_count_o, ovf_o} !== {exp_q.size() > 0, 5'(exp_q.size()), exp_ovf}) begin
                errors++;
                $display("FAIL rnd_fifo_%0d: valid=%b count=%0d ovf=%b, need %b/%0d/%b", n, evt_valid_o,
                         evt_count_o, ovf_o, exp_q.size() > 0, exp_q.size(), exp_ovf);
            end
            checks++;
            if (evt_o !== (exp_q.size() > 0 ? exp_q[0] : 10'h000)) begin
                errors++;
                $display("FAIL rnd_head_%0d: evt=%h, need %h", n, evt_o, exp_q.size() > 0 ? exp_q[0] : 10'h000);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        resetn = 1'b0; code_rx_i = 8'h00; code_rx_v_i = 1'b0;
        evt_rd_i = 1'b0; ovf_clr_i = 1'b0; exp_ovf = 1'b0; exp_pulse = 5'b0;
        test_reset();
        test_make();
        test_ext_break();
        test_pause();
        test_status();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: simulation still running at 2 ms, need completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_decoder.md
PS2_KBD_DECODER -- requirements
Module: ps2_kbd_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets the event FIFO entries; the value SHALL be a power of 2, from 2 to 16.
REQ-002 Parameter PREFIX_TIMEOUT_US, default 2000, sets the max gap in us between the bytes of one multi-byte sequence.
REQ-003 clk6x  in  1  48 MHz system clock; all logic SHALL be on its rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 ck1us  in  1  1-cycle pulse every 1 us.
REQ-006 code_rx_i  in  8  received scan-code byte from the PS2 port.
REQ-007 code_rx_v_i  in  1  1-cycle strobe; code_rx_i is valid this cycle.
REQ-008 evt_o  out  10  FIFO head event {ext, brk, code[7:0]}.
REQ-009 evt_valid_o  out  1  FIFO not empty; evt_o is valid.
REQ-010 evt_rd_i  in  1  pop the head event.
REQ-011 evt_count_o  out  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 ovf_o  out  1  sticky overflow flag.
REQ-013 ovf_clr_i  in  1  clears ovf_o.
REQ-014 ack_o / resend_o / bat_ok_o / kbd_err_o / proto_err_o  out  1 each  1-cycle status pulses.

Function
REQ-015 The decoder FSM SHALL have four states: S_IDLE, S_E0, S_F0 and S_E1SKIP; it SHALL hold an ext register and a 3-bit skip counter.
REQ-016 S_IDLE byte handling:
- E0: go to S_E0 and set ext=1.
- F0: go to S_F0 and set ext=0.
- E1: go to S_E1SKIP with skip=7.
- FA: pulse ack_o.
- FE: pulse resend_o.
- AA: pulse bat_ok_o.
- FC, FD, 00, FF: pulse kbd_err_o.
- Any other byte: push {0,0,byte}.
REQ-017 S_E0: F0 goes to S_F0 with ext kept at 1; E0 stays in S_E0; any other byte pushes {1,0,byte} and returns to S_IDLE.
REQ-018 S_F0: E0, F0 or E1 SHALL pulse proto_err_o and return to S_IDLE with no push; any other byte pushes {ext,1,byte}, then returns to S_IDLE and clears ext.
REQ-019 The fake-shift bytes 0x12 and 0x59 received with ext=1 (in S_E0, or in S_F0 with ext=1) SHALL be dropped without a push; the FSM still returns to S_IDLE.
REQ-020 S_E1SKIP: each byte SHALL decrement skip; the byte that brings skip to 0 pushes {1,0,E1} (Pause) and returns to S_IDLE.
REQ-021 A timer SHALL load PREFIX_TIMEOUT_US on every byte accepted in any state other than S_IDLE, and decrement on ck1us.
REQ-022 If the timer reaches 0 while the FSM is in S_E0, S_F0 or S_E1SKIP, the FSM SHALL pulse proto_err_o, go to S_IDLE and clear ext.
REQ-023 Latency: a push and any status pulse SHALL take effect in cycle N+1 after a strobe in cycle N.
REQ-024 The FIFO SHALL be show-ahead: evt_o always equals the head entry while evt_valid_o=1.
REQ-025 evt_rd_i with an empty FIFO SHALL be ignored.
REQ-026 A push while full without a pop SHALL be dropped, set ovf_o and leave the FIFO contents unchanged.
REQ-027 A push and a pop in the same cycle SHALL both be accepted, including when full; evt_count_o stays unchanged.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 If ovf_clr_i and a new overflow occur in the same cycle, the set SHALL win.
REQ-030 When the decoder pushes and no FIFO slot is free, the FSM state transition SHALL still occur.

Reset
REQ-031 On resetn=0 the block SHALL:
- go to S_IDLE with ext=0, skip=0 and the timer stopped;
- empty the FIFO: pointers=0, evt_count_o=0, evt_valid_o=0;
- drive evt_o=0, ovf_o=0 and all status pulses low.
REQ-032 Reset mid-sequence (for example after E0, F0) SHALL discard the partial sequence; the first byte after reset SHALL be decoded from S_IDLE.

Structure
REQ-033 The shared package ps2_pkg SHALL hold the scan-code constants (E0, E1, F0, FA, FE, AA, FC, FD) and the event field indices.
REQ-034 The FIFO SHALL be the sub-module ps2_evt_fifo, parameterized in width and depth; the FSM and timer SHALL be in ps2_kbd_decoder.

Verification
REQ-035 Byte 1C -> event 0x01C in the next cycle, evt_count_o=1; then evt_rd_i -> evt_valid_o=0.
REQ-036 Bytes E0 F0 75 -> single event 0x375; bytes E0 12 -> no event.
REQ-037 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x2E1; the FSM is back in S_IDLE.
REQ-038 Nine make codes with FIFO_DEPTH=8 and no reads -> evt_count_o=8 and ovf_o=1, with entry 9 lost; a simultaneous push and pop while full -> count stays 8.
REQ-039 Byte E0, then no byte for 2000 us -> proto_err_o pulse; a following 1C gives event 0x01C, not 0x21C.
REQ-040 Bytes FA, AA, FC -> pulses on ack_o, bat_ok_o and kbd_err_o in order, with no FIFO pushes.
